ltc2333_read_deser: RTL and testbench
=====================================

LTC2333_READ_DESER -- requirements
Module: ltc2333_read_deser

Interface
REQ-001 SHALL have parameter NCHAN, default 8: ADC channels per frame.
REQ-002 SHALL have parameter CAPTURE_DELAY, default 2: clk cycles between sck_en and its SDO bit (round trip).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two: output FIFO entries.
REQ-004 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start  in  1: one-cycle pulse, one per conversion (CNV rise).
REQ-007 SHALL have port sck_en  in  1: high for each SCKI pulse the write stage emits, one bit per cycle.
REQ-008 SHALL have port sdo  in  2: serial data, lane0 = ADC0, lane1 = ADC1.
REQ-009 SHALL have port active_channels  in  NCHAN: channel mask, same meaning as write stage.
REQ-010 SHALL have port m_tdata  out  48: {lane1 word[23:0], lane0 word[23:0]}.
REQ-011 SHALL have ports m_tvalid out 1, m_tready in 1, m_tlast out 1, m_tuser out 1: AXI-Stream master.
REQ-012 SHALL have port overflow_cnt  out  8: words dropped on full FIFO, saturating.
REQ-013 SHALL have port frame_err  out  1: sticky, frame restarted mid-word.

Function
REQ-014 SHALL delay sck_en by CAPTURE_DELAY cycles (shift register) to form cap_en; sdo sampled when cap_en=1.
REQ-015 SHALL shift each lane MSB-first into 24-bit registers; word = result[23:6], chan_id[5:3], softspan[2:0].
REQ-016 SHALL use FSM IDLE, SHIFT, PUSH: frame_start -> SHIFT from any state; 24th bit -> PUSH; PUSH -> SHIFT or IDLE.
REQ-017 SHALL clear bit counter (0..23) and word counter on frame_start; frame_start has priority over cap_en same cycle.
REQ-018 SHALL set frame_err if frame_start arrives with bit counter nonzero; partial word discarded.
REQ-019 SHALL in PUSH write both lanes as one entry; m_tlast=1 when word counter = popcount(active_channels)-1.
REQ-020 SHALL return to IDLE after last word; cap_en bits in IDLE ignored (write stage pad clocks).
REQ-021 SHALL treat active_channels=0 as one word per frame, tlast=1 (write stage default channel 0).
REQ-022 SHALL present tvalid 1 cycle after PUSH; transfer on tvalid&&tready; tdata/tlast stable while tvalid&&!tready.
REQ-023 SHALL on PUSH with FIFO full drop the entry, increment overflow_cnt (hold at 255); FIFO contents intact.
REQ-024 SHALL allow simultaneous push and pop when full: pop frees slot, push accepted.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra MSB for full/empty.

Reset
REQ-026 SHALL on aresetn=0 immediately clear: m_tvalid, m_tdata, m_tlast, m_tuser, overflow_cnt, frame_err, FIFO pointers, FSM=IDLE, delay line.
REQ-027 SHALL after release ignore cap_en until first frame_start.

Configuration
REQ-028 SHALL, with LTC2333_READ_IDCHECK_EN defined, compare each lane chan_id to the expected active channel (ascending from lowest set bit, wrapping) and set m_tuser=1 on mismatch in either lane.
REQ-029 SHALL, without LTC2333_READ_IDCHECK_EN, tie m_tuser to 0 and omit the comparison logic.

Verification
REQ-030 active_channels=8'h05, frame_start, 48 cap bits lane0 0x3FFFC_0_7 then 0x00001_2_7 -> two beats, ids 0 and 2, tlast on second only.
REQ-031 m_tready=0, 17 single-channel frames, FIFO_DEPTH=16 -> 16 entries held, overflow_cnt=1, first entry pops correctly.
REQ-032 frame_start after 10 bits -> frame_err=1, no beat; next full frame delivers correct word.
REQ-033 aresetn low mid-SHIFT with 3 entries queued -> tvalid=0 and overflow_cnt=0 same cycle; no beat until new frame.
REQ-034 IDCHECK_EN, mask 8'h03, lane1 second word chan_id=5 -> tuser=1 that beat only; without macro tuser=0.
REQ-035 CAPTURE_DELAY=3, sdo shifted by 3 cycles relative to sck_en -> words match, none bit-shifted.

Source files
------------

// File: rtl/ltc2333_read_deser.sv
// LTC2333 read-side deserializer: captures both SDO lanes, assembles 24-bit words and
// queues lane pairs on an AXI-Stream FIFO. Optional channel-id check: LTC2333_READ_IDCHECK_EN.
module ltc2333_read_deser #(
    parameter int NCHAN         = 8,
    parameter int CAPTURE_DELAY = 2,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             frame_start,
    input  logic             sck_en,
    input  logic [1:0]       sdo,
    input  logic [NCHAN-1:0] active_channels,
    output logic [47:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [7:0]       overflow_cnt,
    output logic             frame_err
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WCW = $clog2(NCHAN) + 1;
    localparam int EW  = 50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } state_t;

    function automatic logic [WCW-1:0] popcount(input logic [NCHAN-1:0] m);
        logic [WCW-1:0] c;
        c = '0;
        for (int i = 0; i < NCHAN; i++) begin
            c = c + {{(WCW-1){1'b0}}, m[i]};
        end
        return c;
    endfunction

`ifdef LTC2333_READ_IDCHECK_EN
    // Channel index of the k-th set bit of the mask (channel 0 when the mask is empty).
    function automatic logic [2:0] nth_chan(input logic [NCHAN-1:0] m, input logic [WCW-1:0] k);
        logic [WCW-1:0] seen;
        logic [2:0]     id;
        logic           found;
        seen  = '0;
        id    = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (m[i] && !found) begin
                if (seen == k) begin
                    id    = i[2:0];
                    found = 1'b1;
                end else begin
                    seen = seen + WCW'(1);
                end
            end
        end
        return id;
    endfunction
`endif

    state_t                 state_q, state_d;
    logic [CAPTURE_DELAY-1:0] cap_sr_q, cap_sr_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]         word_cnt_q, word_cnt_d;
    logic [23:0]            lane0_q, lane0_d, lane1_q, lane1_d;
    logic [23:0]            word0_q, word0_d, word1_q, word1_d;
    logic                   frame_err_q, frame_err_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]             ovf_q, ovf_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic [47:0]            m_tdata_q, m_tdata_d;
    logic                   m_tlast_q, m_tlast_d;
    logic                   m_tuser_q, m_tuser_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];

    logic                   cap_en_s;
    logic [WCW-1:0]         nwords_s;
    logic                   last_word_s;
    logic                   tuser_s;
    logic [EW-1:0]          entry_s;
    logic [EW-1:0]          head_s;
    logic                   push_s, pop_s, full_s, push_ok_s;

    // Round-trip delay line aligning sck_en with the returning SDO bit.
    always_comb begin
        cap_sr_d    = cap_sr_q;
        cap_sr_d[0] = sck_en;
        for (int i = 1; i < CAPTURE_DELAY; i++) begin
            cap_sr_d[i] = cap_sr_q[i-1];
        end
        cap_en_s = cap_sr_q[CAPTURE_DELAY-1];
    end

    // Word framing: channel count, last-word flag and optional channel-id check.
    always_comb begin
        nwords_s = popcount(active_channels);
        if (nwords_s == '0) begin
            nwords_s = WCW'(1);
        end else begin
            nwords_s = nwords_s;
        end
        last_word_s = (word_cnt_q == (nwords_s - WCW'(1)));
`ifdef LTC2333_READ_IDCHECK_EN
        tuser_s = (word0_q[5:3] != nth_chan(active_channels, word_cnt_q)) ||
                  (word1_q[5:3] != nth_chan(active_channels, word_cnt_q));
`else
        tuser_s = 1'b0;
`endif
        entry_s = {tuser_s, last_word_s, word1_q, word0_q};
    end

    // Deserializer FSM next state; frame_start overrides any capture in the same cycle.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        lane0_d     = lane0_q;
        lane1_d     = lane1_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        frame_err_d = frame_err_q;
        if (frame_start) begin
            state_d    = ST_SHIFT;
            bit_cnt_d  = 5'd0;
            word_cnt_d = '0;
            if (bit_cnt_q != 5'd0) begin
                frame_err_d = 1'b1;
            end else begin
                frame_err_d = frame_err_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT, ST_PUSH: begin
                    if ((state_q == ST_PUSH) && last_word_s) begin
                        state_d    = ST_IDLE;
                        word_cnt_d = '0;
                    end else begin
                        if (state_q == ST_PUSH) begin
                            state_d    = ST_SHIFT;
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end else begin
                            state_d = ST_SHIFT;
                        end
                        // A bit may land in the PUSH cycle when the write stage clocks back-to-back.
                        if (cap_en_s) begin
                            lane0_d = {lane0_q[22:0], sdo[0]};
                            lane1_d = {lane1_q[22:0], sdo[1]};
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_d = 5'd0;
                                word0_d   = {lane0_q[22:0], sdo[0]};
                                word1_d   = {lane1_q[22:0], sdo[1]};
                                state_d   = ST_PUSH;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 5'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and output register, which always mirrors the FIFO head.
    always_comb begin
        push_s    = (state_q == ST_PUSH);
        pop_s     = m_tvalid_q && m_tready;
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok_s = push_s && (!full_s || pop_s);
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (push_s && !push_ok_s && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
        // The slot being written this cycle becomes the head only when it bypasses an empty FIFO.
        if (push_ok_s && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
            head_s = entry_s;
        end else begin
            head_s = mem_q[rd_ptr_d[AW-1:0]];
        end
        m_tvalid_d = (rd_ptr_d != wr_ptr_d);
        m_tdata_d  = head_s[47:0];
        m_tlast_d  = head_s[48];
        m_tuser_d  = head_s[49];
    end

    // State, counters and registered AXI-Stream outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cap_sr_q    <= '0;
            bit_cnt_q   <= 5'd0;
            word_cnt_q  <= '0;
            lane0_q     <= 24'd0;
            lane1_q     <= 24'd0;
            word0_q     <= 24'd0;
            word1_q     <= 24'd0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 8'd0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= 48'd0;
            m_tlast_q   <= 1'b0;
            m_tuser_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_sr_q    <= cap_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            lane0_q     <= lane0_d;
            lane1_q     <= lane1_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            m_tuser_q   <= m_tuser_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= entry_s;
        end
    end

    assign m_tvalid     = m_tvalid_q;
    assign m_tdata      = m_tdata_q;
    assign m_tlast      = m_tlast_q;
    assign m_tuser      = m_tuser_q;
    assign overflow_cnt = ovf_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ltc2333_read_deser.sv
// Randomized scoreboard bench for ltc2333_read_deser, built with a 3-cycle capture delay.
module tb_ltc2333_read_deser;
    localparam int TB_CD = 3;

    logic        clk;
    logic        aresetn;
    logic        frame_start;
    logic        sck_en;
    logic [1:0]  sdo;
    logic [7:0]  active_channels;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [7:0]  overflow_cnt;
    logic        frame_err;

    int          checks;
    int          errors;
    int          ready_mode;
    logic [49:0] exp_q [$];
    logic [1:0]  pend [TB_CD];
    logic [23:0] w0 [8];
    logic [23:0] w1 [8];
    bit          stim_done;

    ltc2333_read_deser #(.NCHAN(8), .CAPTURE_DELAY(TB_CD), .FIFO_DEPTH(16)) dut (
        .clk(clk), .aresetn(aresetn), .frame_start(frame_start), .sck_en(sck_en),
        .sdo(sdo), .active_channels(active_channels), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .overflow_cnt(overflow_cnt), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nwords_of(input logic [7:0] m);
        int n;
        n = $countones(m);
        return (n == 0) ? 1 : n;
    endfunction

    // Channel read as word k: set bits ascending, wrapping; empty mask reads channel 0.
    function automatic int chan_of(input logic [7:0] m, input int k);
        int q [$];
        for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
        if (q.size() == 0) return 0;
        return q[k % q.size()];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // One clock of stimulus; sdo returns the lane bits queued TB_CD cycles earlier.
    task automatic tick(input logic fs, input logic sck, input logic [1:0] b);
        @(posedge clk);
        #1;
        frame_start = fs;
        sck_en      = sck;
        sdo         = pend[TB_CD-1];
        for (int i = TB_CD - 1; i > 0; i--) pend[i] = pend[i-1];
        pend[0] = b;
        case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic fill_words(input logic [7:0] m);
        for (int k = 0; k < 8; k++) begin
            w0[k] = {18'($urandom), 3'(chan_of(m, k)), 3'($urandom)};
            w1[k] = {18'($urandom), 3'(chan_of(m, k)), 3'($urandom)};
        end
    endtask

    task automatic send_frame(input logic [7:0] m, input bit store);
        int   n;
        logic tu;
        int   ch;
        n = nwords_of(m);
        active_channels = m;
        tick(1'b1, 1'b0, 2'($urandom));
        for (int k = 0; k < n; k++) begin
            for (int b = 23; b >= 0; b--) begin
                if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 2'($urandom));
                tick(1'b0, 1'b1, {w1[k][b], w0[k][b]});
            end
            ch = chan_of(m, k);
`ifdef LTC2333_READ_IDCHECK_EN
            tu = (int'(w0[k][5:3]) != ch) || (int'(w1[k][5:3]) != ch);
`else
            tu = 1'b0;
`endif
            if (store) exp_q.push_back({tu, (k == n - 1), w1[k], w0[k]});
        end
        repeat (4) tick(1'b0, 1'b1, 2'($urandom));
        repeat (TB_CD + 2) tick(1'b0, 1'b0, 2'($urandom));
    endtask

    task automatic drain(input string nm);
        int budget;
        budget = 3000;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1'b0, 1'b0, 2'($urandom));
            budget--;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        repeat (4) tick(1'b0, 1'b0, 2'($urandom));
    endtask

    initial begin
        checks = 0; errors = 0; ready_mode = 1; stim_done = 1'b0;
        aresetn = 1'b0; frame_start = 1'b0; sck_en = 1'b0; sdo = 2'b00;
        active_channels = 8'h00; m_tready = 1'b0;
        for (int i = 0; i < TB_CD; i++) pend[i] = 2'b00;
        fork
            // Monitor: whenever a beat is presented it must equal the scoreboard head.
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    if (aresetn && m_tvalid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL beat_unexpected got=%h", {m_tuser, m_tlast, m_tdata});
                        end else begin
                            if ({m_tuser, m_tlast, m_tdata} !== exp_q[0]) begin
                                errors++;
                                $display("FAIL beat got=%h want=%h",
                                         {m_tuser, m_tlast, m_tdata}, exp_q[0]);
                            end
                            if (m_tready) void'(exp_q.pop_front());
                        end
                    end
                end
            end
            begin
                #12;
                chk("rst_tvalid", 64'(m_tvalid), 64'd0);
                chk("rst_tdata", 64'(m_tdata), 64'd0);
                chk("rst_tlast", 64'(m_tlast), 64'd0);
                chk("rst_tuser", 64'(m_tuser), 64'd0);
                chk("rst_ovf", 64'(overflow_cnt), 64'd0);
                chk("rst_ferr", 64'(frame_err), 64'd0);
                @(posedge clk); #1;
                aresetn = 1'b1;

                // Clocks before any frame_start must be ignored.
                repeat (30) tick(1'b0, 1'b1, 2'($urandom));
                repeat (TB_CD + 4) tick(1'b0, 1'b0, 2'($urandom));
                chk("pre_frame_idle", 64'(m_tvalid), 64'd0);

                // Two-channel frame with known words; tlast only on the second beat.
                fill_words(8'h05);
                w0[0] = {18'h3FFFC, 3'd0, 3'd7};
                w0[1] = {18'h00001, 3'd2, 3'd7};
                send_frame(8'h05, 1'b1);
                drain("drain_known");

                // Channel-id mismatch on lane1 of the second word.
                fill_words(8'h03);
                w1[1][5:3] = 3'd5;
                send_frame(8'h03, 1'b1);
                drain("drain_idcheck");

                // Empty mask yields a single last word.
                fill_words(8'h00);
                send_frame(8'h00, 1'b1);
                drain("drain_mask0");

                // Randomized frames with random backpressure.
                ready_mode = 2;
                for (int f = 0; f < 20; f++) begin
                    logic [7:0] m;
                    m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    fill_words(m);
                    send_frame(m, 1'b1);
                end
                drain("drain_random");
                chk("ferr_clean", 64'(frame_err), 64'd0);

                // Frame restarted after 10 bits: partial word dropped, sticky error.
                ready_mode = 1;
                active_channels = 8'h01;
                tick(1'b1, 1'b0, 2'b00);
                repeat (10) tick(1'b0, 1'b1, 2'($urandom));
                repeat (TB_CD + 2) tick(1'b0, 1'b0, 2'($urandom));
                chk("ferr_before", 64'(frame_err), 64'd0);
                fill_words(8'h01);
                send_frame(8'h01, 1'b1);
                chk("ferr_set", 64'(frame_err), 64'd1);
                drain("drain_ferr");

                // Overflow: 17 single-word frames into a 16-entry FIFO with no reads.
                ready_mode = 0;
                begin
                    logic [47:0] first;
                    first = 48'd0;
                    for (int f = 0; f < 17; f++) begin
                        fill_words(8'h01);
                        if (f == 0) first = {w1[0], w0[0]};
                        send_frame(8'h01, (f < 16));
                    end
                    chk("ovf_cnt", 64'(overflow_cnt), 64'd1);
                    chk("ovf_tvalid", 64'(m_tvalid), 64'd1);
                    chk("ovf_head", 64'(m_tdata), 64'(first));
                    chk("ovf_depth", 64'(exp_q.size()), 64'd16);
                end
                ready_mode = 1;
                drain("drain_ovf");

                // Reset mid-SHIFT with three entries queued.
                ready_mode = 0;
                for (int f = 0; f < 3; f++) begin
                    fill_words(8'h01);
                    send_frame(8'h01, 1'b1);
                end
                chk("q3_tvalid", 64'(m_tvalid), 64'd1);
                active_channels = 8'h01;
                tick(1'b1, 1'b0, 2'b00);
                repeat (TB_CD + 5) tick(1'b0, 1'b1, 2'($urandom));
                aresetn = 1'b0;
                #1;
                chk("arst_tvalid", 64'(m_tvalid), 64'd0);
                chk("arst_ovf", 64'(overflow_cnt), 64'd0);
                chk("arst_ferr", 64'(frame_err), 64'd0);
                exp_q.delete();
                repeat (2) tick(1'b0, 1'b0, 2'($urandom));
                aresetn = 1'b1;
                ready_mode = 1;
                repeat (20) tick(1'b0, 1'b0, 2'($urandom));
                chk("post_rst_idle", 64'(m_tvalid), 64'd0);
                fill_words(8'h81);
                send_frame(8'h81, 1'b1);
                drain("drain_post_rst");

                stim_done = 1'b1;
                @(negedge clk);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join
    end

endmodule
